multiplier_seq_param: RTL and testbench

- Parametrised iterative multiplier; successor to the fixed 64x64 radix-16 sequential multiplier.
- Operand width and bits retired per cycle are set by parameters.
- Adds signed/unsigned mode, a busy flag and a registered operand capture at start.
- Sits behind the same op_start/op_clear/op_done handshake used by the arithmetic units feeding the datapath.

---
 rtl/multiplier_seq_param.sv | 125 ++++++++++++
 tb/tb_multiplier_seq_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq_param.sv
// Parametrised iterative multiplier.
// Retires STEP multiplier bits per cycle through a shifting partial-product
// datapath. Signed operands are reduced to magnitudes at capture time and the
// product sign is applied in a single fix-up cycle before results are presented.
//
// state | meaning
// IDLE  | waiting for op_start, result held at zero
// MUL   | accumulating one STEP-bit digit per edge
// FIX   | apply product sign, publish result
// DONE  | result valid, op_done high, accepts back-to-back start
module multiplier_seq_param #(
  parameter int WIDTH = 64,
  parameter int STEP  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0]   OP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ACC_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;

  logic [WIDTH-1:0]     mplier_abs;
  logic [WIDTH-1:0]     mcand_abs;
  logic                 neg_next;
  logic [STEP-1:0]      digit;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   fixed_val;

  // Operand magnitudes at capture, current digit partial product and sign fix-up.
  always_comb begin
    mplier_abs = multiplier;
    mcand_abs  = multiplicand;
    neg_next   = 1'b0;
    if (op_signed) begin
      if (multiplier[WIDTH-1])   mplier_abs = (~multiplier) + OP_ONE;
      if (multiplicand[WIDTH-1]) mcand_abs  = (~multiplicand) + OP_ONE;
      neg_next = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
    end
    digit     = mplier_q[STEP-1:0];
    // mcand_q is already shifted into the digit position; the sum of all
    // partials is the true product, so it cannot exceed 2*WIDTH bits.
    partial   = mcand_q * {{(2*WIDTH-STEP){1'b0}}, digit};
    fixed_val = neg_q ? ((~acc_q) + ACC_ONE) : acc_q;
  end

  // Sequencer and datapath registers; op_clear outranks every other request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result   <= '0;
      op_done  <= 1'b0;
      op_busy  <= 1'b0;
    end else if (op_clear) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc_q   <= '0;
      result  <= '0;
      op_done <= 1'b0;
      op_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (op_start) begin
            mplier_q <= mplier_abs;
            mcand_q  <= {{WIDTH{1'b0}}, mcand_abs};
            neg_q    <= neg_next;
            acc_q    <= '0;
            cnt      <= '0;
            result   <= '0;
            op_done  <= 1'b0;
            op_busy  <= 1'b1;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q    <= acc_q + partial;
          mplier_q <= mplier_q >> STEP;
          mcand_q  <= mcand_q << STEP;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result  <= fixed_val;
          op_done <= 1'b1;
          op_busy <= 1'b0;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_seq_param.sv
// Directed bench for multiplier_seq_param: a 64x64/STEP4 instance and an
// 8x8/STEP2 instance share clock and reset.
module tb_multiplier_seq_param;

  logic clk;
  logic reset_n;

  logic          st64, cl64, sg64, busy64, done64;
  logic [63:0]   a64, b64;
  logic [127:0]  res64;

  logic          st8, cl8, sg8, busy8, done8;
  logic [7:0]    a8, b8;
  logic [15:0]   res8;

  int checks;
  int errors;

  multiplier_seq_param #(.WIDTH(64), .STEP(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .op_start(st64), .op_clear(cl64),
    .op_signed(sg64), .multiplier(a64), .multiplicand(b64),
    .op_busy(busy64), .op_done(done64), .result(res64)
  );

  multiplier_seq_param #(.WIDTH(8), .STEP(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .op_start(st8), .op_clear(cl8),
    .op_signed(sg8), .multiplier(a8), .multiplicand(b8),
    .op_busy(busy8), .op_done(done8), .result(res8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Start an operation on the 64-bit instance and wait for op_done.
  // lat counts edges after the start edge; -1 means the wait timed out.
  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic sg,
                       output logic [127:0] res, output int lat, output int busy_cyc,
                       output logic [127:0] mid_res);
    @(negedge clk);
    a64 = a; b64 = b; sg64 = sg; st64 = 1'b1;
    @(negedge clk);
    st64 = 1'b0;
    a64 = 64'hA5A5_5A5A_DEAD_BEEF; b64 = 64'h1234_5678_9ABC_DEF0; sg64 = ~sg;
    mid_res = res64;
    lat = 0; busy_cyc = 0;
    while (!done64 && lat < 40) begin
      if (busy64) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!done64) lat = -1;
    res = res64;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sg8 = sg; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    a8 = 8'h5A; b8 = 8'hC3;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) lat = -1;
    res = res8;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    st64 = 0; cl64 = 0; sg64 = 0; a64 = '0; b64 = '0;
    st8 = 0; cl8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    #23;
    checks++;
    if (res64 !== 128'd0 || done64 !== 1'b0 || busy64 !== 1'b0) begin
      errors++;
      $display("FAIL reset64: result=%h done=%b busy=%b required 0/0/0", res64, done64, busy64);
    end
    checks++;
    if (res8 !== 16'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: result=%h done=%b busy=%b required 0/0/0", res8, done8, busy8);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_unsigned64;
    logic [127:0] r, m;
    int lat, bc;
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, lat, bc, m);
    checks++;
    if (r !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL u64_allones: got %h required fffffffffffffffe0000000000000001", r);
    end
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL u64_latency: got %0d required 17", lat);
    end
    checks++;
    if (bc != 17) begin
      errors++;
      $display("FAIL u64_busy_cycles: got %0d required 17", bc);
    end
    checks++;
    if (m !== 128'd0) begin
      errors++;
      $display("FAIL u64_result_in_mul: got %h required 0", m);
    end
  endtask

  task automatic test_signed64;
    logic [127:0] r, m;
    int lat, bc;
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, r, lat, bc, m);
    checks++;
    if (r !== {128{1'b1}}) begin
      errors++;
      $display("FAIL s64_neg1_x_1: got %h required all ones", r);
    end
    run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, r, lat, bc, m);
    checks++;
    if (r !== 128'h4000_0000_0000_0000_0000_0000_0000_0000) begin
      errors++;
      $display("FAIL s64_min_sq: got %h required 4000...0", r);
    end
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL s64_latency: got %0d required 17", lat);
    end
    run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, r, lat, bc, m);
    checks++;
    if (r !== 128'h4000_0000_0000_0000_0000_0000_0000_0000) begin
      errors++;
      $display("FAIL u64_min_sq: got %h required 4000...0", r);
    end
    run64(64'hFFFF_FFFF_FFFF_FFFD, 64'd1000, 1'b1, r, lat, bc, m);
    checks++;
    if (r !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F448) begin
      errors++;
      $display("FAIL s64_neg3_x_1000: got %h required ...fff448", r);
    end
  endtask

  task automatic test_width8;
    logic [15:0] r;
    int lat;
    run8(8'h80, 8'h80, 1'b1, r, lat);
    checks++;
    if (r !== 16'h4000) begin
      errors++;
      $display("FAIL s8_min_sq: got %h required 4000", r);
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL s8_latency: got %0d required 5", lat);
    end
    run8(8'hF9, 8'h03, 1'b1, r, lat);
    checks++;
    if (r !== 16'hFFEB) begin
      errors++;
      $display("FAIL s8_neg7_x_3: got %h required ffeb", r);
    end
    run8(8'd200, 8'd3, 1'b0, r, lat);
    checks++;
    if (r !== 16'h0258) begin
      errors++;
      $display("FAIL u8_200_x_3: got %h required 0258", r);
    end
    run8(8'd0, 8'd77, 1'b0, r, lat);
    checks++;
    if (r !== 16'h0000 || lat != 5) begin
      errors++;
      $display("FAIL u8_zero: got %h lat %0d required 0000 lat 5", r, lat);
    end
  endtask

  task automatic test_clear;
    logic [127:0] r, m;
    int lat, bc;
    @(negedge clk);
    a64 = 64'd1000; b64 = 64'd1000; sg64 = 1'b0; st64 = 1'b1;
    @(negedge clk);
    st64 = 1'b0;
    repeat (5) @(negedge clk);
    cl64 = 1'b1; st64 = 1'b1; a64 = 64'd9; b64 = 64'd9;
    @(negedge clk);
    cl64 = 1'b0; st64 = 1'b0;
    checks++;
    if (done64 !== 1'b0 || busy64 !== 1'b0 || res64 !== 128'd0) begin
      errors++;
      $display("FAIL clear_mul: done=%b busy=%b result=%h required 0/0/0", done64, busy64, res64);
    end
    @(negedge clk);
    checks++;
    if (busy64 !== 1'b0) begin
      errors++;
      $display("FAIL clear_stays_idle: busy=%b required 0", busy64);
    end
    run64(64'd6, 64'd7, 1'b0, r, lat, bc, m);
    checks++;
    if (r !== 128'd42 || lat != 17) begin
      errors++;
      $display("FAIL clear_then_6x7: got %0d lat %0d required 42 lat 17", r, lat);
    end
    @(negedge clk);
    cl64 = 1'b1;
    @(negedge clk);
    cl64 = 1'b0;
    checks++;
    if (done64 !== 1'b0 || res64 !== 128'd0) begin
      errors++;
      $display("FAIL clear_done: done=%b result=%h required 0/0", done64, res64);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a64 = 64'd5; b64 = 64'd9; sg64 = 1'b0; st64 = 1'b1;
    @(negedge clk);
    st64 = 1'b0;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    st64 = 1'b1; a64 = 64'd100; b64 = 64'd100;
    @(negedge clk); lat++;
    st64 = 1'b0;
    while (!done64 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (res64 !== 128'd45 || lat != 17) begin
      errors++;
      $display("FAIL ignore_start_mul: got %0d lat %0d required 45 lat 17", res64, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] r, m;
    int lat, bc;
    run64(64'd3, 64'd11, 1'b0, r, lat, bc, m);
    checks++;
    if (m !== 128'd0) begin
      errors++;
      $display("FAIL b2b_result_cleared: got %h required 0", m);
    end
    checks++;
    if (r !== 128'd33 || lat != 17) begin
      errors++;
      $display("FAIL b2b_3x11: got %0d lat %0d required 33 lat 17", r, lat);
    end
  endtask

  task automatic test_async_reset;
    logic [127:0] r, m;
    int lat, bc;
    @(negedge clk);
    a64 = 64'd777; b64 = 64'd3; sg64 = 1'b0; st64 = 1'b1;
    @(negedge clk);
    st64 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 128'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h required 0/0/0", busy64, done64, res64);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run64(64'd123, 64'd456, 1'b0, r, lat, bc, m);
    checks++;
    if (r !== 128'd56088 || lat != 17) begin
      errors++;
      $display("FAIL post_reset_123x456: got %0d lat %0d required 56088 lat 17", r, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned64();
    test_signed64();
    test_width8();
    test_clear();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
